// File: rtl/sar_adc_ctrl.sv
// rtl/sar_adc_ctrl.sv - SAR ADC controller (bias warmup, 8-bit binary search); SAR_MAJORITY_EN enables 2-of-3 voted decisions
module sar_adc_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int BIAS_WARMUP   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic       hi_bias,
  input  logic       cmp,
  output logic [7:0] dac_code,
  output logic       en_resh,
  output logic       en_resl,
  output logic       busy,
  output logic       done,
  output logic [7:0] result
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WARMUP = 3'd1,
    SETTLE = 3'd2,
    DECIDE = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam logic [7:0] WARM_LAST   = 8'(BIAS_WARMUP - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic       hib_q, hib_d;
  logic [7:0] code_q, code_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] result_q, result_d;
  logic       done_q, done_d;
  logic       cmp_s1_q, cmp_s2_q;
  logic       cmp_s;
`ifdef SAR_MAJORITY_EN
  logic [1:0] vote_q, vote_d;
`endif

  assign cmp_s = cmp_s2_q;

  // State, working registers and the two-flop comparator synchronizer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hib_q    <= 1'b0;
      code_q   <= 8'h00;
      idx_q    <= 3'd7;
      cnt_q    <= 8'h00;
      result_q <= 8'h00;
      done_q   <= 1'b0;
      cmp_s1_q <= 1'b0;
      cmp_s2_q <= 1'b0;
`ifdef SAR_MAJORITY_EN
      vote_q   <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      hib_q    <= hib_d;
      code_q   <= code_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      cmp_s1_q <= cmp;
      cmp_s2_q <= cmp_s1_q;
`ifdef SAR_MAJORITY_EN
      vote_q   <= vote_d;
`endif
    end
  end

  // Next-state logic: warmup, then per bit a settle window and a decision
  always_comb begin
    state_d  = state_q;
    hib_d    = hib_q;
    code_d   = code_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
`ifdef SAR_MAJORITY_EN
    vote_d   = vote_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && ena) begin
          hib_d   = hi_bias;
          code_d  = 8'h00;
          idx_d   = 3'd7;
          cnt_d   = 8'h00;
          state_d = WARMUP;
        end
      end
      WARMUP: begin
        if (cnt_q == WARM_LAST) begin
          cnt_d   = 8'h00;
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = 8'h00;
          state_d = DECIDE;
`ifdef SAR_MAJORITY_EN
          vote_d  = 2'd0;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DECIDE: begin
`ifdef SAR_MAJORITY_EN
        // Third sample: two of the three synchronized samples must agree
        if (cnt_q == 8'd2) begin
          code_d[idx_q] = ((vote_q + {1'b0, cmp_s}) >= 2'd2);
          cnt_d         = 8'h00;
          if (idx_q == 3'd0) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx_q - 3'd1;
            state_d = SETTLE;
          end
        end else begin
          vote_d = vote_q + {1'b0, cmp_s};
          cnt_d  = cnt_q + 8'd1;
        end
`else
        code_d[idx_q] = cmp_s;
        cnt_d         = 8'h00;
        if (idx_q == 3'd0) begin
          state_d = FINISH;
        end else begin
          idx_d   = idx_q - 3'd1;
          state_d = SETTLE;
        end
`endif
      end
      FINISH: begin
        result_d = code_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Dropping ena aborts any conversion without touching the result
    if (state_q != IDLE && !ena) begin
      state_d  = IDLE;
      result_d = result_q;
      done_d   = 1'b0;
    end
  end

  // Output decode from the current state
  always_comb begin
    dac_code = 8'h00;
    en_resh  = 1'b0;
    en_resl  = 1'b0;
    busy     = 1'b0;
    case (state_q)
      WARMUP: dac_code = 8'h80;
      SETTLE: dac_code = code_q | (8'b1 << idx_q);
      DECIDE: dac_code = code_q | (8'b1 << idx_q);
      FINISH: dac_code = code_q;
      default: dac_code = 8'h00;
    endcase
    if (state_q != IDLE) begin
      busy    = 1'b1;
      en_resh = hib_q;
      en_resl = ~hib_q;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb/tb_sar_adc_ctrl.sv - self-checking bench for sar_adc_ctrl against a binary-search reference model
module tb_sar_adc_ctrl;

  localparam int WARM = 16;
  localparam int SETL = 4;
`ifdef SAR_MAJORITY_EN
  localparam int DEC = 3;
`else
  localparam int DEC = 1;
`endif
  localparam int LAT = WARM + 8 * (SETL + DEC) + 1;

  logic       clk = 1'b0;
  logic       rst_n, ena, start, hi_bias, cmp;
  logic [7:0] dac_code, result;
  logic       en_resh, en_resl, busy, done;
  logic [7:0] vin;
  logic       glitch;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_trial [8];
  logic [7:0] m_res;
  logic [7:0] exp_result;

  sar_adc_ctrl #(.SETTLE_CYCLES(SETL), .BIAS_WARMUP(WARM)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .start    (start),
    .hi_bias  (hi_bias),
    .cmp      (cmp),
    .dac_code (dac_code),
    .en_resh  (en_resh),
    .en_resl  (en_resl),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  // Ideal comparator with an optional one-cycle inversion
  assign cmp = (vin >= dac_code) ^ glitch;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain binary search of vin, recording each trial code
  task automatic sar_model(input logic [7:0] v);
    logic [7:0] code;
    logic [7:0] t;
    code = 8'h00;
    for (int b = 7; b >= 0; b--) begin
      t = code | (8'h01 << b);
      m_trial[7 - b] = t;
      if (v >= t) code = t;
    end
    m_res = code;
  endtask

  task automatic run_conv(input logic [7:0] v, input logic hb, input int restart_at,
                          input int abort_at, input int reset_at, input int glitch_at);
    int  dones;
    logic disrupted;
    sar_model(v);
    vin = v; hi_bias = hb; ena = 1'b1; start = 1'b1;
    step();
    start = 1'b0; hi_bias = ~hb;
    check("busy_after_start", busy, 1);
    check("en_resh_active", en_resh, hb);
    check("en_resl_active", en_resl, !hb);
    dones = 0;
    disrupted = 1'b0;
    for (int n = 1; n <= LAT + 2; n++) begin
      start  = (n == restart_at);
      if (abort_at != 0 && n >= abort_at) ena = 1'b0;
      rst_n  = !(n == reset_at);
      glitch = (glitch_at != 0 && n == glitch_at + 1);
      step();
      if (done) dones++;
      if (n == abort_at) begin
        disrupted = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_en_resh", en_resh, 0);
        check("abort_en_resl", en_resl, 0);
        check("abort_result_kept", result, exp_result);
      end
      if (n == reset_at) begin
        disrupted = 1'b1;
        exp_result = 8'h00;
        check("rst_dac", dac_code, 0);
        check("rst_result", result, exp_result);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_en", {en_resh, en_resl}, 0);
      end
      if (!disrupted) begin
        for (int k = 0; k < 8; k++)
          if (n == WARM + k * (SETL + DEC)) check($sformatf("trial%0d", k), dac_code, m_trial[k]);
        if (n == LAT - 1) begin
          check("busy_before_done", busy, 1);
          check("no_early_done", done, 0);
        end
        if (n == LAT) begin
          exp_result = m_res;
          check("done_at_latency", done, 1);
          check("result", result, exp_result);
          check("busy_at_done", busy, 0);
          check("en_off_after_done", {en_resh, en_resl}, 0);
          check("dac_idle", dac_code, 0);
        end
        if (n == LAT + 1) check("done_one_cycle", done, 0);
      end
    end
    check("done_count", dones, disrupted ? 0 : 1);
    ena = 1'b1; rst_n = 1'b1; start = 1'b0; glitch = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; start = 1'b0; hi_bias = 1'b0; vin = 8'h00; glitch = 1'b0;
    exp_result = 8'h00;
    step();
    step();
    check("reset_dac", dac_code, 0);
    check("reset_result", result, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_en", {en_resh, en_resl}, 0);
    rst_n = 1'b1;
    step();

    start = 1'b1; ena = 1'b0;
    step();
    start = 1'b0;
    check("start_without_ena_ignored", busy, 0);
    ena = 1'b1;
    step();

    run_conv(8'hA5, 1'b1, 0, 0, 0, 0);
    run_conv(8'h00, 1'b1, 0, 0, 0, 0);
    run_conv(8'hFF, 1'b0, 0, 0, 0, 0);
    run_conv(8'($urandom_range(1, 254)), 1'($urandom), 20, 0, 0, 0);
    run_conv(8'($urandom), 1'($urandom), 0, 30, 0, 0);
    run_conv(8'($urandom), 1'($urandom), 0, 0, 0, 0);
    run_conv(8'($urandom), 1'($urandom), 0, 0, 40, 0);
    check("result_after_reset", result, exp_result);
    for (int i = 0; i < 3; i++) run_conv(8'($urandom), 1'($urandom), 0, 0, 0, 0);
`ifdef SAR_MAJORITY_EN
    run_conv(8'hA5, 1'b1, 0, 0, 0, WARM + SETL - 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sar_adc_ctrl.md
SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line; the block SHALL implement these exactly:
- SETTLE_CYCLES, 4, cycles waited after each DAC code update before the decision; legal range 2..15.
- BIAS_WARMUP, 16, cycles the bias generator is enabled before the first trial; legal range 1..255.
REQ-002 Ports (name, direction, width, meaning), one per line; the block SHALL provide exactly these:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- ena  in  1  design enable; low aborts and holds IDLE.
- start  in  1  conversion request, sampled in IDLE only.
- hi_bias  in  1  bias select, latched at start: 1 = EN_RESH path, 0 = EN_RESL path.
- cmp  in  1  asynchronous comparator output from the op-amp; 1 = input above DAC level.
- dac_code  out  8  trial code driving the R2R DAC.
- en_resh  out  1  high-side bias enable.
- en_resl  out  1  low-side bias enable.
- busy  out  1  high from the cycle after start acceptance until done or abort.
- done  out  1  one-cycle pulse when result updates.
- result  out  8  last completed conversion, held until the next completion.

Function
REQ-003 cmp SHALL pass through a 2-flop synchronizer; only the synchronized value (cmp_s) is used.
REQ-004 FSM states SHALL be IDLE, WARMUP, SETTLE, DECIDE, FINISH.
REQ-005 IDLE: when start=1 and ena=1, the block SHALL latch hi_bias, clear the working code, load the bit index with 7 and enter WARMUP; busy=1 from the next cycle.
REQ-006 During WARMUP, SETTLE, DECIDE and FINISH, en_resh SHALL equal the latched hi_bias, en_resl SHALL equal its inverse, and both SHALL be 0 in IDLE.
REQ-007 WARMUP SHALL last BIAS_WARMUP cycles; dac_code=0x80 is driven during WARMUP.
REQ-008 SETTLE SHALL last SETTLE_CYCLES cycles with dac_code = working code OR (1 << bit index).
REQ-009 DECIDE SHALL last 1 cycle: the trial bit is kept if cmp_s=1 and cleared otherwise; if the bit index is 0, go to FINISH, else decrement the index and go to SETTLE.
REQ-010 FINISH SHALL last 1 cycle: result ← working code, done=1, then return to IDLE.
REQ-011 Latency from the start-sampling edge to the done pulse SHALL be BIAS_WARMUP + 8×(SETTLE_CYCLES+1) + 1 cycles (57 at defaults).
REQ-012 dac_code SHALL be 0x00 in IDLE.
REQ-013 start while busy SHALL be ignored, with no queuing.
REQ-014 ena=0 in any non-IDLE state SHALL force IDLE on the next edge: busy=0, bias enables 0, no done, result unchanged.
REQ-015 If start=1 and ena=0 in the same cycle, the block SHALL ignore the request.
REQ-016 result SHALL update only in FINISH.
REQ-017 done SHALL never be asserted for more than one consecutive cycle.

Reset
REQ-018 When rst_n=0 at a clock edge, the block SHALL enter IDLE, clear the synchronizer flops, and drive dac_code=0x00, result=0x00, busy=0, done=0, en_resh=0, en_resl=0.
REQ-019 Reset mid-conversion SHALL discard the conversion with no done pulse.

Configuration
REQ-020 Macro SAR_MAJORITY_EN, when defined: DECIDE SHALL last 3 cycles and the bit decision SHALL be the 2-of-3 majority of cmp_s sampled in those cycles; latency becomes BIAS_WARMUP + 8×(SETTLE_CYCLES+3) + 1 (73 at defaults).
REQ-021 When SAR_MAJORITY_EN is undefined, DECIDE SHALL be the single-cycle sample of REQ-009.

Verification
REQ-022 The bench SHALL cover these directed scenarios, with the comparator model cmp = (vin ≥ dac_code):
- vin=0xA5, start pulse -> done exactly 57 cycles later, result=0xA5, dac_code trials 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
- vin=0x00, then vin=0xFF -> results 0x00 and 0xFF respectively; en_resh/en_resl follow hi_bias=1/0 respectively, and are 0 after done.
- start re-pulsed at cycle 20 of a conversion -> ignored; one done only; a start after done begins a new conversion.
- ena dropped at cycle 30 -> busy=0, bias enables 0 next cycle, no done, result keeps its prior value.
- rst_n low for 1 cycle at cycle 40 -> all outputs at reset values next cycle; no done.
- With SAR_MAJORITY_EN defined, vin=0xA5 and a 1-cycle inverted glitch injected on cmp_s during the DECIDE of bit 7 -> result=0xA5, done at cycle 73.
